rename_freelist: RTL

Physical-register free-list controller for the dual-issue rename stage. It holds the names of unallocated physical registers and hands up to two of them to decode per cycle. Up to two stale names return from ROB retirement per cycle. On a pipeline flush it rolls back every speculative allocation in a single cycle. It is instantiated twice: once for the GPR file and once for the T-bit file.

---
 rtl/rename_freelist.sv | 86 ++++++++
 1 files changed

// File: rtl/rename_freelist.sv
// Physical-register free list for a dual-issue rename stage: two offers per cycle,
// two compacted returns per cycle, single-cycle rollback of speculative allocations on flush.
module rename_freelist #(
  parameter int PREGS = 32,
  parameter int AREGS = 16,
  parameter int TAG_W = 5
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            alloc_req,
  input  logic [1:0]            freelist_en,
  output logic [1:0]            freelist_rdy,
  output logic [1:0][TAG_W-1:0] next_free,
  input  logic [1:0]            ret_en,
  input  logic [1:0][TAG_W-1:0] ret_tag,
  input  logic                  flush,
  output logic [TAG_W:0]        free_count,
  output logic                  fl_err
);
  localparam int DEPTH = PREGS - AREGS;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = TAG_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, arch_head, tail, head_p1, tail_p1, arch_head_nx;
  logic [CW-1:0]    count, arch_count;
  logic [1:0]       n_alloc, n_ret, alloc_eff, ret_eff;
  logic             illegal, ovf;

  // Pointer advance modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign head_p1 = wrap_add(head, 2'd1);
  assign tail_p1 = wrap_add(tail, 2'd1);

  assign freelist_rdy[0] = (count != '0);
  assign freelist_rdy[1] = (count >= (alloc_req[0] ? CW'(2) : CW'(1)));
  assign next_free[0]    = mem[head];
  assign next_free[1]    = alloc_req[0] ? mem[head_p1] : mem[head];
  assign free_count      = count;

  always_comb begin
    n_alloc = {1'b0, freelist_en[0]} + {1'b0, freelist_en[1]};
    n_ret   = {1'b0, ret_en[0]} + {1'b0, ret_en[1]};
    illegal = (freelist_en[0] && !(alloc_req[0] && freelist_rdy[0])) ||
              (freelist_en[1] && !(alloc_req[1] && freelist_rdy[1])) ||
              (freelist_en[1] && alloc_req[0] && !freelist_en[0]);
    // A bad enable drops the whole allocation; a flush discards it too.
    alloc_eff = (illegal || flush) ? 2'd0 : n_alloc;
    // More names coming back than the list can hold means a double free.
    ovf = ({1'b0, count} + (CW+1)'(n_ret)) > ((CW+1)'(DEPTH) + (CW+1)'(alloc_eff));
    ret_eff = ovf ? 2'd0 : n_ret;
    arch_head_nx = wrap_add(arch_head, ret_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(AREGS + i);
      head       <= '0;
      arch_head  <= '0;
      tail       <= '0;
      count      <= CW'(DEPTH);
      arch_count <= CW'(DEPTH);
      fl_err     <= 1'b0;
    end else begin
      if (ret_eff != 2'd0) mem[tail]    <= ret_en[0] ? ret_tag[0] : ret_tag[1];
      if (ret_eff == 2'd2) mem[tail_p1] <= ret_tag[1];
      tail      <= wrap_add(tail, ret_eff);
      arch_head <= arch_head_nx;
      // Returns push at tail and advance arch_head equally, so arch_count holds.
      if (flush) begin
        head  <= arch_head_nx;
        count <= arch_count;
      end else begin
        head  <= wrap_add(head, alloc_eff);
        count <= count + CW'(ret_eff) - CW'(alloc_eff);
      end
      fl_err <= fl_err | illegal | ovf;
    end
  end
endmodule
